// File: rtl/dot_sched_pkg.sv
// Shared types and sizing helpers for the dot-product scheduler.
package dot_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width that stays at least one bit wide for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: full signed product plus growth for DIMENSION terms.
  function automatic int acc_w(input int width, input int dim);
    return 2 * width + $clog2(dim);
  endfunction

endpackage

// File: rtl/dot_mac.sv
// Signed multiply-accumulate: acc += sext(a*b) on each enabled cycle, clr zeroes it.
module dot_mac #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   r_acc;

  assign w_prod = a * b;

  // Accumulator: clear has priority; the size cast sign-extends the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (en) begin
      if (clr) r_acc <= '0;
      else     r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/dot_sched.sv
// Round-robin scheduler that serves one requester's dot product at a time
// on a shared multiply-accumulate engine.
module dot_sched
  import dot_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [NREQ-1:0]                        req,
  input  logic [NREQ*DIMENSION*WIDTH-1:0]        v1_bus,
  input  logic [NREQ*DIMENSION*WIDTH-1:0]        v2_bus,
  output logic [NREQ-1:0]                        ack,
  output logic signed [acc_w(WIDTH,DIMENSION)-1:0] result,
  output logic [idx_w(NREQ)-1:0]                 gnt_id,
  output logic                                   busy
);

  localparam int ACC_W = acc_w(WIDTH, DIMENSION);
  localparam int IDX_W = idx_w(NREQ);
  localparam int CNT_W = idx_w(DIMENSION);

  state_e                  r_state, w_state_next;
  logic [IDX_W-1:0]        r_gnt_id, r_last_grant, w_winner, w_cand;
  logic [CNT_W-1:0]        r_count;
  logic                    w_grant, w_last;
  logic signed [ACC_W-1:0] w_acc, r_result;

  logic signed [WIDTH-1:0] w_v1_arr [NREQ][DIMENSION];
  logic signed [WIDTH-1:0] w_v2_arr [NREQ][DIMENSION];
  logic signed [WIDTH-1:0] r_v1 [DIMENSION];
  logic signed [WIDTH-1:0] r_v2 [DIMENSION];

  // Unpack the flat operand buses into [requester][element] views.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    for (genvar gk = 0; gk < DIMENSION; gk++) begin : g_elem
      assign w_v1_arr[gi][gk] = v1_bus[(gi*DIMENSION+gk)*WIDTH +: WIDTH];
      assign w_v2_arr[gi][gk] = v2_bus[(gi*DIMENSION+gk)*WIDTH +: WIDTH];
    end
  end

  // Round-robin pick: scan downward so the first requester after last_grant wins.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(r_last_grant) + k) % NREQ);
      if (req[w_cand]) w_winner = w_cand;
    end
  end

  // Next-state logic; a grant only happens from IDLE on an enabled cycle.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_last       = (r_count == CNT_W'(DIMENSION-1));
    case (r_state)
      ST_IDLE: begin
        if (en && (|req)) begin
          w_grant      = 1'b1;
          w_state_next = ST_MAC;
        end
      end
      ST_MAC:  if (en && w_last) w_state_next = ST_DONE;
      ST_DONE: if (en) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; en low freezes the FSM wherever it is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else if (en) r_state <= w_state_next;
  end

  // Grant bookkeeping, element counter and the held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt_id     <= '0;
      r_last_grant <= IDX_W'(NREQ-1);
      r_count      <= '0;
      r_result     <= '0;
    end else if (en) begin
      if (w_grant) begin
        r_gnt_id <= w_winner;
        r_count  <= '0;
      end else if (r_state == ST_MAC) begin
        r_count  <= w_last ? '0 : r_count + 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_result     <= w_acc;
        r_last_grant <= r_gnt_id;
      end
    end
  end

  // Operand snapshot taken at the grant edge so requesters may change afterwards.
  for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_opnd
    always_ff @(posedge clk) begin
      if (en && w_grant) begin
        r_v1[gi] <= w_v1_arr[w_winner][gi];
        r_v2[gi] <= w_v2_arr[w_winner][gi];
      end
    end
  end

  dot_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (en && (w_grant || (r_state == ST_MAC))),
    .clr (w_grant),
    .a   (r_v1[r_count]),
    .b   (r_v2[r_count]),
    .acc (w_acc)
  );

  // Completion pulse goes only to the served requester, and only in DONE.
  always_comb begin
    ack = '0;
    if (r_state == ST_DONE) ack[r_gnt_id] = 1'b1;
  end

  // In DONE the finished accumulator is shown directly; it is captured on leaving.
  assign result = (r_state == ST_DONE) ? w_acc : r_result;
  assign gnt_id = r_gnt_id;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dot_sched.sv
// Self-checking bench for dot_sched: vector table plus multi-cycle corner sequences,
// with a scoreboard queue checked whenever an ack pulse appears.
module tb_dot_sched;

  localparam int NREQ = 4;
  localparam int DIM  = 16;
  localparam int W    = 8;
  localparam int ACCW = 2*W + $clog2(DIM);
  localparam int LAT  = DIM + 2;

  logic                      clk, rst, en;
  logic [NREQ-1:0]           req;
  logic [NREQ*DIM*W-1:0]     v1_bus, v2_bus;
  logic [NREQ-1:0]           ack;
  logic signed [ACCW-1:0]    result;
  logic [1:0]                gnt_id;
  logic                      busy;

  dot_sched #(.NREQ(NREQ), .DIMENSION(DIM), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .v1_bus(v1_bus), .v2_bus(v2_bus),
    .ack(ack), .result(result), .gnt_id(gnt_id), .busy(busy)
  );

  typedef struct { int id; longint res; } exp_t;
  typedef struct { logic [3:0] req; int a; int b; int id; int res; } vec_t;

  exp_t exp_q [$];
  int   ack_cyc_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   ack_cnt = 0;
  logic [NREQ-1:0] prev_ack = '0;
  logic prev_en = 1'b0;
  int   ra [DIM];
  int   rb [DIM];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint req_v);
    n_checks++;
    if (act != req_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int r, input int a, input int b);
    for (int i = 0; i < DIM; i++) begin
      v1_bus[(r*DIM+i)*W +: W] = W'(a);
      v2_bus[(r*DIM+i)*W +: W] = W'(b);
    end
  endtask

  task automatic fill_junk();
    for (int r = 0; r < NREQ; r++) fill(r, 11, 13);
  endtask

  task automatic load_arr(input int r);
    for (int i = 0; i < DIM; i++) begin
      v1_bus[(r*DIM+i)*W +: W] = W'(ra[i]);
      v2_bus[(r*DIM+i)*W +: W] = W'(rb[i]);
    end
  endtask

  function automatic longint dot_arr();
    longint s = 0;
    for (int i = 0; i < DIM; i++) s += longint'(ra[i]) * longint'(rb[i]);
    return s;
  endfunction

  task automatic wait_acks(input int target, input int budget, input string nm);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (ack_cnt < target) begin
      n_errors++;
      $display("FAIL %s_timeout: acks %0d, required %0d", nm, ack_cnt, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Scoreboard: every new ack pulse pops one expected job and is compared.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && ack != 0 && prev_ack == 0) begin
      ack_cnt++;
      ack_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: got ack %b, required no ack", ack);
      end else begin
        e = exp_q.pop_front();
        check("ack_vector", longint'(ack), longint'(1) << e.id);
        check("ack_gnt_id", longint'(gnt_id), e.id);
        check("ack_result", longint'(result), e.res);
        check("ack_busy", longint'(busy), 1);
        $display("job id=%0d result=%0d at cycle %0d", gnt_id, result, cyc);
      end
    end
    if (rst && prev_ack != 0 && prev_en) check("ack_one_cycle", longint'(ack), 0);
    prev_ack = ack;
    prev_en  = en;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int g, tgt, lat1, base;
    longint e38;
    bit seen;

    vecs[0] = '{4'b0001,    3,    2, 0,      96};
    vecs[1] = '{4'b0001, -128, -128, 0,  262144};
    vecs[2] = '{4'b0001, -128,  127, 0, -260096};
    vecs[3] = '{4'b1010,    5,   -7, 1,    -560};
    vecs[4] = '{4'b1010,  100,  100, 3,  160000};
    vecs[5] = '{4'b1001,   -1,    1, 0,     -16};
    vecs[6] = '{4'b0110,  127,  127, 1,  258064};
    vecs[7] = '{4'b0100,   -7,    9, 2,   -1008};

    rst = 1'b0; en = 1'b1; req = '0; v1_bus = '0; v2_bus = '0;
    repeat (2) tick();
    check("reset_ack",    longint'(ack), 0);
    check("reset_result", longint'(result), 0);
    check("reset_gnt_id", longint'(gnt_id), 0);
    check("reset_busy",   longint'(busy), 0);
    rst = 1'b1;
    repeat (3) tick();
    check("idle_busy", longint'(busy), 0);
    check("idle_ack",  longint'(ack), 0);

    // Table-driven single jobs, each on an idle engine.
    for (int v = 0; v < 8; v++) begin
      fill_junk();
      fill(vecs[v].id, vecs[v].a, vecs[v].b);
      exp_q.push_back('{vecs[v].id, longint'(vecs[v].res)});
      tgt = ack_cnt + 1;
      g = cyc;
      req = vecs[v].req;
      tick();
      req = '0;
      check($sformatf("busy_after_grant_v%0d", v), longint'(busy), 1);
      wait_acks(tgt, 60, $sformatf("vec%0d", v));
      if (ack_cyc_q.size() > 0)
        check($sformatf("latency_v%0d", v), ack_cyc_q[$] - g + 1, LAT);
    end

    // Full load: all requesters pending, order 0,1,2,3,0 at fixed spacing.
    do_reset();
    for (int r = 0; r < NREQ; r++) fill(r, r + 1, -(r + 2));
    for (int k = 0; k < 5; k++) exp_q.push_back('{k % NREQ, 16 * ((k % NREQ) + 1) * -((k % NREQ) + 2)});
    ack_cyc_q.delete();
    tgt = ack_cnt + 5;
    req = 4'b1111;
    wait_acks(tgt, 200, "full_load");
    req = '0;
    if (ack_cyc_q.size() == 5)
      for (int k = 1; k < 5; k++)
        check($sformatf("spacing_%0d", k), ack_cyc_q[k] - ack_cyc_q[k-1], LAT);

    // Operands changed one cycle after the grant must not affect the result.
    do_reset();
    fill_junk();
    for (int i = 0; i < DIM; i++) begin ra[i] = i * 9 - 70; rb[i] = 50 - i * 7; end
    load_arr(1);
    e38 = dot_arr();
    exp_q.push_back('{1, e38});
    tgt = ack_cnt + 1;
    req = 4'b0010;
    tick();
    check("grant_id_r1", longint'(gnt_id), 1);
    tick();
    for (int i = 0; i < DIM; i++) begin ra[i] = 127 - i; rb[i] = -i * 8; end
    load_arr(1);
    req = '0;
    wait_acks(tgt, 60, "operand_change");

    // Reference run, then the same job with en low for 5 cycles mid-MAC.
    fill_junk();
    fill(2, -9, 77);
    exp_q.push_back('{2, 16 * -9 * 77});
    tgt = ack_cnt + 1;
    g = cyc;
    req = 4'b0100;
    tick();
    req = '0;
    wait_acks(tgt, 60, "ref_run");
    lat1 = (ack_cyc_q.size() > 0) ? ack_cyc_q[$] - g + 1 : 0;
    exp_q.push_back('{2, 16 * -9 * 77});
    tgt = ack_cnt + 1;
    g = cyc;
    req = 4'b0100;
    tick();
    req = '0;
    repeat (5) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    wait_acks(tgt, 60, "freeze_run");
    if (ack_cyc_q.size() > 0) check("freeze_latency", ack_cyc_q[$] - g + 1, lat1 + 5);

    // Freeze while in DONE: ack stays high and counts as one pulse.
    exp_q.push_back('{2, 16 * -9 * 77});
    base = ack_cnt;
    seen = 1'b0;
    req = 4'b0100;
    tick();
    req = '0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (ack != 0) seen = 1'b1;
    end
    check("done_reached", longint'(seen), 1);
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("ack_held_%0d", n), longint'(ack), 4'b0100);
    end
    en = 1'b1;
    tick();
    check("ack_released", longint'(ack), 0);
    check("frozen_single_pulse", ack_cnt - base, 1);

    // Reset mid-job at count 7: outputs drop without a clock edge, no ack follows.
    fill(3, 20, 30);
    exp_q.push_back('{3, 9600});
    tgt = ack_cnt + 1;
    req = 4'b1000;
    tick();
    req = '0;
    wait_acks(tgt, 60, "pre_abort");
    base = ack_cnt;
    req = 4'b1000;
    tick();
    req = '0;
    repeat (7) tick();
    check("busy_before_abort", longint'(busy), 1);
    rst = 1'b0;
    #1;
    check("abort_ack",    longint'(ack), 0);
    check("abort_result", longint'(result), 0);
    check("abort_gnt_id", longint'(gnt_id), 0);
    check("abort_busy",   longint'(busy), 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (25) tick();
    check("no_ack_after_abort", ack_cnt - base, 0);
    fill(2, 6, -5);
    exp_q.push_back('{2, -480});
    tgt = ack_cnt + 1;
    req = 4'b0100;
    tick();
    req = '0;
    wait_acks(tgt, 60, "post_abort");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
